// File: rtl/log_sched.sv
// Round-robin, credit-controlled scheduler sharing one pipelined Log unit
// between two sample channels, with per-channel show-ahead result FIFOs.
module log_sched #(
    parameter int Bus_size_in = 47,
    parameter int Bus_size_out = 30,
    parameter int LAT = 2,
    parameter int DEPTH = 4,
    parameter logic [Bus_size_in:0] IDLE_VAL = 48'h800000000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    input  logic [Bus_size_in:0]  req0_data,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [Bus_size_in:0]  req1_data,
    output logic                  req1_ready,
    output logic [Bus_size_in:0]  log_in,
    input  logic [Bus_size_out:0] log_out,
    output logic                  out0_valid,
    output logic [Bus_size_out:0] out0_data,
    input  logic                  out0_ready,
    output logic                  out1_valid,
    output logic [Bus_size_out:0] out1_data,
    input  logic                  out1_ready,
    output logic [15:0]           zero_cnt
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OW = AW + 1;
    localparam int CW = $clog2(DEPTH + LAT + 2) + 1;

    typedef logic [Bus_size_in:0] din_t;
    typedef logic [Bus_size_out:0] dout_t;
    typedef struct packed {
        logic vld;
        logic ch;
    } tag_t;

    logic [1:0] rv;
    logic [1:0] ordy;
    din_t       rd [2];

    assign rv    = {req1_valid, req0_valid};
    assign ordy  = {out1_ready, out0_ready};
    assign rd[0] = req0_data;
    assign rd[1] = req1_data;

    // Stage 0 travels alongside log_in; stage LAT lines up with log_out.
    tag_t          tag_q [LAT+1];
    logic [OW-1:0] occ_q [2];
    logic [AW-1:0] wp_q  [2];
    logic [AW-1:0] rp_q  [2];
    dout_t         mem_q [2][DEPTH];

    din_t        login_q, login_d;
    logic [15:0] zc_q, zc_d;
    logic        last_q, last_d;

    logic [CW-1:0] infl [2];
    logic [1:0]    elig;
    logic [1:0]    gnt;
    logic [1:0]    push;
    logic [1:0]    pop;
    din_t          samp;

    always_comb begin
        for (int c = 0; c < 2; c++) begin
            infl[c] = '0;
            for (int s = 0; s <= LAT; s++) begin
                if (tag_q[s].vld && (tag_q[s].ch == c[0]))
                    infl[c] = infl[c] + CW'(1);
            end
            elig[c] = rst && rv[c] &&
                      ((CW'(occ_q[c]) + infl[c]) < CW'(DEPTH));
            push[c] = tag_q[LAT].vld && (tag_q[LAT].ch == c[0]);
            pop[c]  = (occ_q[c] != '0) && ordy[c];
        end
    end

    // last_q names the channel granted most recently.
    always_comb begin
        gnt    = 2'b00;
        last_d = last_q;
        unique case (elig)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last_q ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
        if (gnt != 2'b00)
            last_d = gnt[1];
    end

    assign samp = gnt[1] ? rd[1] : rd[0];

    always_comb begin
        login_d = IDLE_VAL;
        zc_d    = zc_q;
        if (gnt != 2'b00) begin
            if (samp == '0) begin
                login_d = din_t'(1);
                if (zc_q != 16'hFFFF)
                    zc_d = zc_q + 16'd1;
            end else begin
                login_d = samp;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            login_q <= IDLE_VAL;
            zc_q    <= '0;
            last_q  <= 1'b1;
            for (int s = 0; s <= LAT; s++)
                tag_q[s] <= '0;
        end else begin
            login_q  <= login_d;
            zc_q     <= zc_d;
            last_q   <= last_d;
            tag_q[0] <= tag_t'{vld: gnt != 2'b00, ch: gnt[1]};
            for (int s = 1; s <= LAT; s++)
                tag_q[s] <= tag_q[s-1];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int c = 0; c < 2; c++) begin
                occ_q[c] <= '0;
                wp_q[c]  <= '0;
                rp_q[c]  <= '0;
                for (int i = 0; i < DEPTH; i++)
                    mem_q[c][i] <= '0;
            end
        end else begin
            for (int c = 0; c < 2; c++) begin
                if (push[c]) begin
                    mem_q[c][wp_q[c]] <= log_out;
                    wp_q[c] <= wp_q[c] + AW'(1);
                end
                if (pop[c])
                    rp_q[c] <= rp_q[c] + AW'(1);
                occ_q[c] <= occ_q[c] + OW'(push[c]) - OW'(pop[c]);
            end
        end
    end

    assign log_in     = login_q;
    assign zero_cnt   = zc_q;
    assign req0_ready = gnt[0];
    assign req1_ready = gnt[1];
    assign out0_valid = occ_q[0] != '0;
    assign out1_valid = occ_q[1] != '0;
    assign out0_data  = out0_valid ? mem_q[0][rp_q[0]] : '0;
    assign out1_data  = out1_valid ? mem_q[1][rp_q[1]] : '0;

    a_nofull0: assert property (@(posedge clk) disable iff (!rst)
        !(push[0] && occ_q[0] == OW'(DEPTH)));
    a_nofull1: assert property (@(posedge clk) disable iff (!rst)
        !(push[1] && occ_q[1] == OW'(DEPTH)));

endmodule

// File: tb/tb_log_sched.sv
// Bench for log_sched: stub Log pipeline, queue-based reference model,
// per-cycle comparison plus directed literal checks.
module tb_log_sched;

    localparam int LAT = 2;
    localparam int DEPTH = 4;
    localparam logic [47:0] IDLE = 48'h800000000000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic [47:0] req0_data = '0, req1_data = '0;
    logic        out0_ready = 1'b0, out1_ready = 1'b0;
    logic        req0_ready, req1_ready;
    logic [47:0] log_in;
    logic [30:0] log_out = '0;
    logic [47:0] lp1 = '0;
    logic        out0_valid, out1_valid;
    logic [30:0] out0_data, out1_data;
    logic [15:0] zero_cnt;

    always #5 clk = ~clk;

    log_sched dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .log_in(log_in), .log_out(log_out),
        .out0_valid(out0_valid), .out0_data(out0_data), .out0_ready(out0_ready),
        .out1_valid(out1_valid), .out1_data(out1_data), .out1_ready(out1_ready),
        .zero_cnt(zero_cnt)
    );

    function automatic logic [30:0] lfn(input logic [47:0] x);
        return 31'(x >> 17) ^ (31'(x[16:0]) * 31'd3);
    endfunction

    // Stand-in Log unit: result valid LAT edges after log_in is loaded.
    always @(posedge clk) begin
        lp1     <= log_in;
        log_out <= lfn(lp1);
    end

    typedef struct {
        logic [30:0] d;
        int          rt;
    } ent_t;

    ent_t        q0[$];
    ent_t        q1[$];
    int          cyc = 0;
    logic        m_last = 1'b1;
    logic [47:0] m_login = IDLE;
    logic [15:0] m_zc = '0;
    logic        d_g0 = 0, d_g1 = 0, d_p0 = 0, d_p1 = 0;
    logic [47:0] d_samp = '0;
    int          pops0 = 0, pops1 = 0;
    int          n_tests = 0, n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin : cmp
        logic        e0, e1, v0, v1;
        logic [30:0] x0, x1;
        e0   = rst && req0_valid && (q0.size() < DEPTH);
        e1   = rst && req1_valid && (q1.size() < DEPTH);
        d_g0 = e0 && (!e1 || m_last);
        d_g1 = e1 && (!e0 || !m_last);
        v0   = rst && (q0.size() > 0) && (q0[0].rt <= cyc);
        v1   = rst && (q1.size() > 0) && (q1[0].rt <= cyc);
        x0   = v0 ? q0[0].d : 31'd0;
        x1   = v1 ? q1[0].d : 31'd0;
        d_p0 = v0 && out0_ready;
        d_p1 = v1 && out1_ready;
        d_samp = d_g1 ? req1_data : req0_data;
        chk("req0_ready", req0_ready, d_g0);
        chk("req1_ready", req1_ready, d_g1);
        chk("log_in", log_in, rst ? m_login : IDLE);
        chk("zero_cnt", zero_cnt, rst ? m_zc : 16'h0);
        chk("out0_valid", out0_valid, v0);
        chk("out0_data", out0_data, x0);
        chk("out1_valid", out1_valid, v1);
        chk("out1_data", out1_data, x1);
    end

    always @(posedge clk) begin : mdl
        logic [47:0] sub;
        ent_t        e;
        if (!rst) begin
            q0.delete();
            q1.delete();
            m_last  = 1'b1;
            m_login = IDLE;
            m_zc    = '0;
        end else begin
            if (d_p0) begin void'(q0.pop_front()); pops0++; end
            if (d_p1) begin void'(q1.pop_front()); pops1++; end
            if (d_g0 || d_g1) begin
                sub = (d_samp == 48'h0) ? 48'h1 : d_samp;
                if (d_samp == 48'h0 && m_zc != 16'hFFFF)
                    m_zc = m_zc + 16'd1;
                m_login = sub;
                e.d  = lfn(sub);
                e.rt = cyc + LAT + 2;
                if (d_g1) q1.push_back(e);
                else      q0.push_back(e);
                m_last = d_g1;
            end else begin
                m_login = IDLE;
            end
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    function automatic logic [47:0] rnd48();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return ($urandom_range(7) == 0) ? 48'h0 : r[47:0];
    endfunction

    initial begin : stim
        int a0, a1, p, s0, s1;
        logic prev;
        prev = 1'b0;
        // T1: reset holds everything idle, even with requests pending
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        chk("t1_log_in", log_in, 48'h800000000000);
        chk("t1_ready0", req0_ready, 1'b0);
        chk("t1_ready1", req1_ready, 1'b0);
        chk("t1_zero", zero_cnt, 16'h0);
        idle();
        tick();
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            @(negedge clk);
            chk("t1_nospur", {out0_valid, out1_valid}, 2'b00);
        end
        // T2: single request, latency and data
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        tick();
        req0_valid = 1'b1;
        req0_data  = 48'h400000000000;
        @(negedge clk);
        chk("t2_ready", req0_ready, 1'b1);
        tick();
        idle();
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk("t2_valid", out0_valid, k == 4);
            chk("t2_ch1", out1_valid, 1'b0);
            if (k == 4) chk("t2_data", out0_data, 31'h20000000);
            if (k < 4) tick();
        end
        repeat (8) tick();
        // T3: fairness
        s0 = pops0;
        s1 = pops1;
        for (int i = 0; i < 20; i++) begin
            tick();
            req0_valid = 1'b1;
            req1_valid = 1'b1;
            req0_data  = rnd48();
            req1_data  = rnd48();
            @(negedge clk);
            chk("t3_onehot", 2'(req0_ready) + 2'(req1_ready), 2'd1);
            if (i > 0) chk("t3_alt", req1_ready, !prev);
            prev = req1_ready;
        end
        tick();
        idle();
        repeat (12) tick();
        chk("t3_res0", pops0 - s0, 10);
        chk("t3_res1", pops1 - s1, 10);
        // T4: back-pressure on channel 0
        out0_ready = 1'b0;
        a0 = 0;
        a1 = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            req0_valid = 1'b1;
            req1_valid = 1'b1;
            req0_data  = rnd48();
            req1_data  = rnd48();
            @(negedge clk);
            a0 += int'(req0_ready);
            a1 += int'(req1_ready);
        end
        chk("t4_acc0", a0, DEPTH);
        chk("t4_ch1_runs", a1 >= 5, 1'b1);
        tick();
        out0_ready = 1'b1;
        p = pops0;
        tick();
        @(negedge clk);
        chk("t4_resume", req0_ready, 1'b1);
        tick();
        idle();
        repeat (12) tick();
        chk("t4_drain", pops0 - p >= 4, 1'b1);
        // T5: zero substitution after a fresh reset
        rst = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        req1_valid = 1'b1;
        req1_data  = 48'h0;
        @(negedge clk);
        chk("t5_ready", req1_ready, 1'b1);
        tick();
        idle();
        @(negedge clk);
        chk("t5_log_in", log_in, 48'h000000000001);
        chk("t5_zero", zero_cnt, 16'h1);
        repeat (8) tick();
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            tick();
            req0_valid = 1'($urandom_range(1));
            req1_valid = 1'($urandom_range(1));
            req0_data  = rnd48();
            req1_data  = rnd48();
            out0_ready = $urandom_range(9) < 7;
            out1_ready = $urandom_range(9) < 7;
        end
        tick();
        idle();
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        repeat (12) tick();
        // T6: reset with results buffered and in flight
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        req0_valid = 1'b1;
        req0_data  = 48'h123456789ABC;
        repeat (4) tick();
        idle();
        tick();
        chk("t6_pre", out0_valid, 1'b1);
        rst = 1'b0;
        #1;
        chk("t6_valid", {out0_valid, out1_valid}, 2'b00);
        chk("t6_log_in", log_in, IDLE);
        chk("t6_zero", zero_cnt, 16'h0);
        chk("t6_data", out0_data, 31'h0);
        repeat (2) tick();
        rst = 1'b1;
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            @(negedge clk);
            chk("t6_empty", {out0_valid, out1_valid}, 2'b00);
        end
        // T5b: zero counter saturation
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_data  = 48'h0;
        req1_data  = 48'h0;
        repeat (65600) tick();
        idle();
        @(negedge clk);
        chk("t5_sat", zero_cnt, 16'hFFFF);
        repeat (10) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
